// File: rtl/bootram_loader_pkg.sv
// Shared types and constants for the boot RAM image loader: FSM states,
// frame constants and byte-address to lane/word split helpers.
package bootram_loader_pkg;

  localparam int          CNT_W     = 14;
  localparam int          LANE_AW   = 11;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [15:0] MAX_LEN   = 16'd8192;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  function automatic logic [1:0] lane_of(input logic [CNT_W-1:0] b);
    return b[1:0];
  endfunction

  // b never exceeds 8191 when written, so bit 13 is dropped
  function automatic logic [LANE_AW-1:0] word_of(input logic [CNT_W-1:0] b);
    return b[LANE_AW+1:2];
  endfunction

endpackage

// File: rtl/bootram_addr_gen.sv
// Byte counter for the image load; turns each write into a registered
// lane word address and one-hot lane enable.
module bootram_addr_gen
  import bootram_loader_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int NUM_LANES = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_W-1:0]     cnt,
  output logic [ADDR_W-1:0]    ram_ad,
  output logic [NUM_LANES-1:0] ram_ce
);

  // a write issued alongside clr still targets the pre-clear address
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      ram_ad <= '0;
      ram_ce <= '0;
    end else begin
      ram_ce <= '0;
      if (inc) begin
        ram_ad <= word_of(cnt);
        ram_ce <= NUM_LANES'(1) << lane_of(cnt);
      end
      if (clr)      cnt <= '0;
      else if (inc) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bootram_loader.sv
// Loads a framed byte stream into the four boot RAM lanes and holds the
// CPU in reset until a length- and checksum-valid image is in place.
module bootram_loader
  import bootram_loader_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int NUM_LANES = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [ADDR_W-1:0]    ram_ad,
  output logic [7:0]           ram_din,
  output logic [NUM_LANES-1:0] ram_ce,
  output logic                 ram_wre,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 cpu_resetn
);

  state_t           state;
  logic [7:0]       len_lo;
  logic [7:0]       sum;
  logic [CNT_W-1:0] last;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      len_full;
  logic             xfer, wr_xfer, len_ok;

  assign xfer     = rx_valid & rx_ready;
  assign wr_xfer  = xfer && (state == S_DATA);
  assign len_full = {rx_data, len_lo};
  assign len_ok   = (len_full != 16'd0) && (len_full <= MAX_LEN);

  bootram_addr_gen #(.ADDR_W(ADDR_W), .NUM_LANES(NUM_LANES)) u_addr (
    .clk    (clk),
    .resetn (resetn),
    .clr    (start),
    .inc    (wr_xfer),
    .cnt    (cnt),
    .ram_ad (ram_ad),
    .ram_ce (ram_ce)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      len_lo     <= '0;
      sum        <= '0;
      last       <= '0;
      rx_ready   <= 1'b0;
      ram_din    <= '0;
      ram_wre    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_resetn <= 1'b0;
    end else begin
      // data write path runs independently of start so an accepted byte lands
      ram_wre <= wr_xfer;
      if (wr_xfer) ram_din <= rx_data;

      if (start) begin
        state      <= S_SYNC;
        rx_ready   <= 1'b1;
        busy       <= 1'b1;
        done       <= 1'b0;
        err        <= 1'b0;
        cpu_resetn <= 1'b0;
        sum        <= '0;
      end else if (xfer) begin
        case (state)
          S_SYNC:   if (rx_data == SYNC_BYTE) state <= S_LEN_LO;
          S_LEN_LO: begin
            len_lo <= rx_data;
            state  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            if (len_ok) begin
              last  <= CNT_W'(len_full - 16'd1);
              state <= S_DATA;
            end else begin
              state    <= S_ERR;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
            end
          end
          S_DATA: begin
            sum <= sum + rx_data;
            if (cnt == last) state <= S_CSUM;
          end
          S_CSUM: begin
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            if (rx_data == sum) begin
              state      <= S_DONE;
              done       <= 1'b1;
              cpu_resetn <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bootram_loader.sv
// Directed bench for bootram_loader: a frame-level model predicts every
// output cycle by cycle, plus literal checks on the resulting RAM image.
module tb_bootram_loader;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [10:0] ram_ad;
  logic [7:0]  ram_din;
  logic [3:0]  ram_ce;
  logic        ram_wre, busy, done, err, cpu_resetn;

  int checks = 0;
  int fails  = 0;

  bootram_loader #(.ADDR_W(11), .NUM_LANES(4)) dut (
    .clk(clk), .resetn(resetn), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .ram_ad(ram_ad),
    .ram_din(ram_din), .ram_ce(ram_ce), .ram_wre(ram_wre), .busy(busy),
    .done(done), .err(err), .cpu_resetn(cpu_resetn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // RAM lanes behind the loader; preloaded with a recognisable init image
  logic [7:0] bmem [8192];
  int wr_count = 0;
  initial for (int i = 0; i < 8192; i++) bmem[i] = 8'hEE;
  always @(posedge clk) begin
    if (ram_wre) begin
      wr_count <= wr_count + 1;
      for (int l = 0; l < 4; l++)
        if (ram_ce[l]) bmem[int'(ram_ad) * 4 + l] <= ram_din;
    end
  end

  // frame-level model: byte position within frame decides what happens
  logic       m_rdy = 0, m_busy = 0, m_done = 0, m_err = 0, m_cpu = 0;
  logic       e_wre = 0;
  logic [3:0] e_ce = 0;
  int         e_ad = 0, e_din = 0;
  bit         hunting = 0, inframe = 0;
  int         pos = 0, mlen = 0, msum = 0;

  task automatic model_end(input bit good);
    m_rdy = 0; m_busy = 0; hunting = 0; inframe = 0;
    if (good) begin m_done = 1; m_cpu = 1; end
    else m_err = 1;
  endtask

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      m_rdy = 0; m_busy = 0; m_done = 0; m_err = 0; m_cpu = 0;
      e_wre = 0; e_ce = 0; e_ad = 0; e_din = 0; hunting = 0; inframe = 0;
    end else begin
      e_wre = 0; e_ce = 0;
      if (rx_valid && m_rdy) begin
        if (hunting) begin
          if (rx_data == 8'hA5) begin hunting = 0; inframe = 1; pos = 0; end
        end else if (inframe) begin
          if (pos == 0) mlen = int'(rx_data);
          else if (pos == 1) begin
            mlen = mlen + 256 * int'(rx_data);
            if (mlen == 0 || mlen > 8192) model_end(0);
          end else if (pos < mlen + 2) begin
            e_wre = 1;
            e_ad  = (pos - 2) / 4;
            e_ce  = 4'(1 << ((pos - 2) % 4));
            e_din = int'(rx_data);
            msum  = msum + int'(rx_data);
          end else model_end(int'(rx_data) == (msum % 256));
          pos++;
        end
      end
      if (start) begin
        hunting = 1; inframe = 0; msum = 0;
        m_rdy = 1; m_busy = 1; m_done = 0; m_err = 0; m_cpu = 0;
      end
    end
  end

  bit cmp_en = 0;
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("rx_ready", rx_ready, m_rdy);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("cpu_resetn", cpu_resetn, m_cpu);
      chk("ram_wre", ram_wre, e_wre);
      chk("ram_ce", ram_ce, e_ce);
      if (e_wre) begin
        chk("ram_ad", ram_ad, e_ad);
        chk("ram_din", ram_din, e_din);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1; idle(1); start = 0;
  endtask

  // holds the byte until it is accepted; returns cycles spent
  task automatic send_byte(input logic [7:0] b, output int n);
    bit ok;
    rx_valid = 1; rx_data = b; n = 0;
    do begin
      ok = rx_ready;
      idle(1);
      n++;
    end while (!ok && n < 50);
    chk("handshake", ok, 1);
  endtask

  task automatic send_frame(input logic [7:0] q [$]);
    int n;
    foreach (q[i]) send_byte(q[i], n);
    rx_valid = 0;
  endtask

  int n, wsum, wbase;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    cmp_en = 1;
    idle(1);
    resetn = 1;
    idle(2);
    chk("rst rx_ready", rx_ready, 0);
    chk("rst ram_ad", ram_ad, 0);
    chk("rst ram_ce", ram_ce, 0);
    chk("rst cpu_resetn", cpu_resetn, 0);

    // basic 4-byte image with leading garbage before sync
    wbase = wr_count;
    pulse_start();
    chk("rx_ready after start", rx_ready, 1);
    send_frame('{8'h00, 8'hFF, 8'hA5, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA});
    idle(2);
    chk("basic done", done, 1);
    chk("basic cpu_resetn", cpu_resetn, 1);
    chk("basic err", err, 0);
    chk("basic writes", wr_count - wbase, 4);
    chk("basic mem0", bmem[0], 8'h11);
    chk("basic mem3", bmem[3], 8'h44);

    // bad checksum, then recovery
    wbase = wr_count;
    pulse_start();
    chk("restart clears done", done, 0);
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h7E, 8'h7F});
    idle(2);
    chk("csum err", err, 1);
    chk("csum cpu_resetn", cpu_resetn, 0);
    chk("csum writes", wr_count - wbase, 1);
    chk("csum mem0", bmem[0], 8'h7E);
    chk("csum mem1 kept", bmem[1], 8'h22);
    pulse_start();
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03});
    idle(2);
    chk("recover done", done, 1);

    // length bounds
    wbase = wr_count;
    pulse_start();
    send_frame('{8'hA5, 8'h00, 8'h00});
    idle(2);
    chk("len0 err", err, 1);
    pulse_start();
    send_frame('{8'hA5, 8'h01, 8'h20});
    idle(2);
    chk("len8193 err", err, 1);
    chk("badlen writes", wr_count - wbase, 0);

    // full 8 KB image, back-to-back, data = b[7:0]; checksum is 0x00
    wbase = wr_count;
    pulse_start();
    send_frame('{8'hA5, 8'h00, 8'h20});
    rx_valid = 1;
    wsum = 0;
    for (int i = 0; i < 8192; i++) begin
      send_byte(8'(i), n);
      wsum += n;
    end
    send_byte(8'h00, n);
    rx_valid = 0;
    idle(2);
    chk("full cycles", wsum, 8192);
    chk("full writes", wr_count - wbase, 8192);
    chk("full last", bmem[8191], 8'hFF);
    chk("full mid", bmem[4660], 8'h34);
    chk("full done", done, 1);

    // reset while byte 3 of data is being written
    pulse_start();
    send_frame('{8'hA5, 8'h08, 8'h00, 8'h90, 8'h91, 8'h92});
    rx_valid = 1; rx_data = 8'h93;
    idle(1);
    rx_valid = 0;
    resetn = 0;
    #1;
    chk("mid rst ram_wre", ram_wre, 0);
    chk("mid rst ram_ce", ram_ce, 0);
    chk("mid rst ram_ad", ram_ad, 0);
    chk("mid rst ram_din", ram_din, 0);
    chk("mid rst busy", busy, 0);
    idle(2);
    resetn = 1;
    idle(1);
    chk("mid rst mem2", bmem[2], 8'h92);
    chk("mid rst mem3 kept", bmem[3], 8'h03);
    pulse_start();
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h5A, 8'h5A});
    idle(2);
    chk("post rst done", done, 1);
    chk("post rst mem0", bmem[0], 8'h5A);

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
